auth_msg_receiver: RTL and testbench

AUTH_MSG_RECEIVER -- requirements
Module: auth_msg_receiver

---
 rtl/auth_msg_receiver.sv | 186 ++++++++++++++++++
 tb/tb_auth_msg_receiver.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_msg_receiver.sv
// Receives optionally USB-framed auth messages byte by byte, validates them and
// posts a compact request word into a per-source pending register.
module auth_msg_receiver #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 64,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [7:0]                           rx_byte,
  input  logic                                 rx_valid,
  input  logic                                 rx_last,
  input  logic                                 rx_src,
  input  logic                                 usb_framed,
  output logic                                 rx_ready,
  output logic [7:0]                           bmRequestType,
  output logic [7:0]                           bRequest,
  output logic [15:0]                          wLength,
  output logic [31:0]                          header,
  output logic                                 payload_wr_en,
  output logic [$clog2(MAX_PAYLOAD_BYTES)-1:0] payload_wr_addr,
  output logic [7:0]                           payload_wr_data,
  output logic [7:0]                           pending_auth_request_PD,
  output logic [7:0]                           pending_auth_request_DEBUG,
  input  logic                                 pending_auth_request_PD_erase,
  input  logic                                 pending_auth_request_DEBUG_erase,
  output logic                                 Ack_out,
  output logic                                 Error_msg_malformed,
  output logic                                 Error_timeout
);

  localparam int unsigned AW = $clog2(MAX_PAYLOAD_BYTES);
  localparam int unsigned CW = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, USB_HDR, AUTH_HDR, PAYLOAD, DISCARD, CHECK, POST, ACK
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] pay_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          src_q;
  logic          framed_q;
  logic          bad;

  logic          accept;
  logic          pay_room;
  logic          type_ok;
  logic          check_bad;
  logic          post_free;
  logic          waiting;
  logic          tmo_fire;
  logic [7:0]    msg_type;
  logic [7:0]    word;

  assign rx_ready        = !(state inside {CHECK, POST, ACK});
  assign accept          = rx_valid && rx_ready;
  assign pay_room        = pay_cnt < CW'(MAX_PAYLOAD_BYTES);

  // Payload write port is combinational so the byte lands in the cycle it is accepted
  assign payload_wr_en   = (state == PAYLOAD) && rx_valid && pay_room;
  assign payload_wr_addr = payload_wr_en ? AW'(pay_cnt) : '0;
  assign payload_wr_data = payload_wr_en ? rx_byte : '0;

  assign msg_type  = header[23:16];
  assign type_ok   = msg_type inside {8'h01, 8'h02, 8'h03, 8'h41, 8'h42, 8'h43, 8'h7F};
  assign check_bad = bad || (header[31:24] != 8'h01) || !type_ok ||
                     (framed_q && (wLength != (16'(pay_cnt) + 16'd4)));
  assign word      = {header[9:8],
                      ((msg_type >= 8'h01) && (msg_type <= 8'h03)) ? 2'b01 : 2'b10,
                      1'b0, framed_q, msg_type[1:0]};
  assign post_free = src_q ? (pending_auth_request_DEBUG == 8'h00)
                           : (pending_auth_request_PD == 8'h00);

  // A free target in POST always wins over an expiring timeout
  assign waiting  = (state inside {USB_HDR, AUTH_HDR, PAYLOAD, DISCARD, POST}) && !accept;
  assign tmo_fire = waiting && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                    !((state == POST) && post_free);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                      <= IDLE;
      idx                        <= '0;
      pay_cnt                    <= '0;
      tmo_cnt                    <= '0;
      src_q                      <= 1'b0;
      framed_q                   <= 1'b0;
      bad                        <= 1'b0;
      bmRequestType              <= '0;
      bRequest                   <= '0;
      wLength                    <= '0;
      header                     <= '0;
      pending_auth_request_PD    <= '0;
      pending_auth_request_DEBUG <= '0;
      Ack_out                    <= 1'b0;
      Error_msg_malformed        <= 1'b0;
      Error_timeout              <= 1'b0;
    end else begin
      Ack_out             <= 1'b0;
      Error_msg_malformed <= 1'b0;
      Error_timeout       <= 1'b0;

      // Erase first so a POST write in the same cycle overrides it
      if (pending_auth_request_PD_erase)    pending_auth_request_PD    <= '0;
      if (pending_auth_request_DEBUG_erase) pending_auth_request_DEBUG <= '0;

      if (accept)       tmo_cnt <= '0;
      else if (waiting) tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_fire) begin
        Error_timeout <= 1'b1;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            src_q         <= rx_src;
            framed_q      <= usb_framed;
            bad           <= 1'b0;
            pay_cnt       <= '0;
            idx           <= 2'd1;
            bRequest      <= '0;
            wLength       <= '0;
            bmRequestType <= usb_framed ? rx_byte : 8'h00;
            header        <= usb_framed ? 32'h0 : {24'h0, rx_byte};
            if (rx_last) begin
              bad   <= 1'b1;
              state <= CHECK;
            end else begin
              state <= usb_framed ? USB_HDR : AUTH_HDR;
            end
          end
          USB_HDR: if (accept) begin
            case (idx)
              2'd1:    bRequest       <= rx_byte;
              2'd2:    wLength[7:0]   <= rx_byte;
              default: wLength[15:8]  <= rx_byte;
            endcase
            idx <= idx + 2'd1;
            if (rx_last) begin
              bad   <= 1'b1;
              state <= CHECK;
            end else if (idx == 2'd3) begin
              state <= AUTH_HDR;
            end
          end
          AUTH_HDR: if (accept) begin
            header <= {header[23:0], rx_byte};
            idx    <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= rx_last ? CHECK : PAYLOAD;
            end else if (rx_last) begin
              bad   <= 1'b1;
              state <= CHECK;
            end
          end
          PAYLOAD: if (accept) begin
            if (pay_room) pay_cnt <= pay_cnt + CW'(1);
            else          bad     <= 1'b1;
            if (rx_last)       state <= CHECK;
            else if (!pay_room) state <= DISCARD;
          end
          DISCARD: if (accept && rx_last) state <= CHECK;
          CHECK: begin
            if (check_bad) begin
              Error_msg_malformed <= 1'b1;
              state               <= IDLE;
            end else begin
              tmo_cnt <= '0;
              state   <= POST;
            end
          end
          POST: if (post_free) begin
            if (src_q) pending_auth_request_DEBUG <= word;
            else       pending_auth_request_PD    <= word;
            Ack_out <= 1'b1;
            state   <= ACK;
          end
          ACK:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auth_msg_receiver.sv
// Directed and randomized checks of auth_msg_receiver against a message-level
// outcome model (accept / malformed / timeout, request word, payload writes).
module tb_auth_msg_receiver;

  localparam int unsigned MAXP = 64;
  localparam int unsigned TMO  = 50;
  localparam int unsigned AW   = $clog2(MAXP);
  localparam int OUT_NONE = 0, OUT_ACK = 1, OUT_MAL = 2, OUT_TMO = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_byte;
  logic          rx_valid, rx_last, rx_src, usb_framed;
  logic          rx_ready;
  logic [7:0]    bmRequestType, bRequest;
  logic [15:0]   wLength;
  logic [31:0]   header;
  logic          payload_wr_en;
  logic [AW-1:0] payload_wr_addr;
  logic [7:0]    payload_wr_data;
  logic [7:0]    pend_pd, pend_dbg;
  logic          erase_pd, erase_dbg;
  logic          Ack_out, Error_msg_malformed, Error_timeout;
  logic [2:0]    pulses;

  auth_msg_receiver #(.MAX_PAYLOAD_BYTES(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_last(rx_last),
    .rx_src(rx_src), .usb_framed(usb_framed), .rx_ready(rx_ready),
    .bmRequestType(bmRequestType), .bRequest(bRequest), .wLength(wLength), .header(header),
    .payload_wr_en(payload_wr_en), .payload_wr_addr(payload_wr_addr),
    .payload_wr_data(payload_wr_data),
    .pending_auth_request_PD(pend_pd), .pending_auth_request_DEBUG(pend_dbg),
    .pending_auth_request_PD_erase(erase_pd), .pending_auth_request_DEBUG_erase(erase_dbg),
    .Ack_out(Ack_out), .Error_msg_malformed(Error_msg_malformed), .Error_timeout(Error_timeout)
  );

  always #5 clk = ~clk;
  assign pulses = {Ack_out, Error_msg_malformed, Error_timeout};

  int errors = 0;
  int checks = 0;
  logic [7:0]        strm[$];
  logic [7:0]        pay_q[$];
  logic [AW+7:0]     wr_q[$];
  logic [7:0]        mt_list[7] = '{8'h01, 8'h02, 8'h03, 8'h41, 8'h42, 8'h43, 8'h7F};

  always @(negedge clk) if (payload_wr_en) wr_q.push_back({payload_wr_addr, payload_wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Message-level expected outcome
  function automatic int model_outcome(input logic framed, input logic [31:0] usb_w,
                                       input logic [31:0] hdr_w, input int n_pay, input int trunc);
    logic [7:0] mt;
    int wl;
    mt = hdr_w[23:16];
    wl = int'({usb_w[7:0], usb_w[15:8]});
    if (trunc >= 0) return OUT_MAL;
    if (n_pay > int'(MAXP)) return OUT_MAL;
    if (hdr_w[31:24] != 8'h01) return OUT_MAL;
    if (!(mt inside {8'h01, 8'h02, 8'h03, 8'h41, 8'h42, 8'h43, 8'h7F})) return OUT_MAL;
    if (framed && (wl != 4 + n_pay)) return OUT_MAL;
    return OUT_ACK;
  endfunction

  function automatic logic [7:0] model_word(input logic framed, input logic [31:0] hdr_w);
    logic [7:0] mt;
    logic [1:0] role;
    mt   = hdr_w[23:16];
    role = (mt >= 8'h01 && mt <= 8'h03) ? 2'b01 : 2'b10;
    return {hdr_w[9:8], role, 1'b0, framed, mt[1:0]};
  endfunction

  task automatic build(input logic framed, input logic [31:0] usb_w, input logic [31:0] hdr_w,
                       input int n_pay);
    strm = {};
    pay_q = {};
    if (framed) for (int i = 3; i >= 0; i--) strm.push_back(usb_w[8*i +: 8]);
    for (int i = 3; i >= 0; i--) strm.push_back(hdr_w[8*i +: 8]);
    for (int i = 0; i < n_pay; i++) begin
      pay_q.push_back(8'($urandom));
      strm.push_back(pay_q[i]);
    end
  endtask

  // src/framed only matter on byte 0; later bytes carry noise on them
  task automatic drive_range(input int from, input int to, input int last_idx,
                             input logic src, input logic framed);
    for (int i = from; i <= to; i++) begin
      @(posedge clk); #1;
      rx_valid   = 1'b1;
      rx_byte    = strm[i];
      rx_last    = (i == last_idx);
      rx_src     = (i == 0) ? src : 1'($urandom);
      usb_framed = (i == 0) ? framed : 1'($urandom);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic wait_outcome(input int limit, output int outc, output int k, output logic rdy1);
    outc = OUT_NONE;
    k    = 0;
    rdy1 = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      idle_cycle();
      @(negedge clk);
      if (i == 1) rdy1 = rx_ready;
      if (pulses != 3'b000) begin
        outc = Ack_out ? OUT_ACK : (Error_msg_malformed ? OUT_MAL : OUT_TMO);
        k    = i;
        break;
      end
    end
  endtask

  task automatic erase(input logic src);
    @(posedge clk); #1;
    if (src) erase_dbg = 1'b1; else erase_pd = 1'b1;
    @(posedge clk); #1;
    erase_pd  = 1'b0;
    erase_dbg = 1'b0;
    @(negedge clk);
    check("erase.cleared", src ? pend_dbg : pend_pd, 0);
  endtask

  task automatic run_msg(input string tag, input logic src, input logic framed,
                         input logic [31:0] usb_w, input logic [31:0] hdr_w,
                         input int n_pay, input int trunc, input bit do_erase);
    int exp_out, got, k, nlast, nwr;
    logic rdy;
    logic [7:0] pd0, dbg0, w;
    build(framed, usb_w, hdr_w, n_pay);
    nlast = (trunc >= 0) ? trunc : strm.size() - 1;
    pd0 = pend_pd;
    dbg0 = pend_dbg;
    wr_q = {};
    drive_range(0, nlast, nlast, src, framed);
    wait_outcome(8, got, k, rdy);
    exp_out = model_outcome(framed, usb_w, hdr_w, n_pay, trunc);
    w = model_word(framed, hdr_w);
    check({tag, ".outcome"}, got, exp_out);
    check({tag, ".latency"}, k, (exp_out == OUT_ACK) ? 3 : 2);
    check({tag, ".ready_in_check"}, rdy, 0);
    check({tag, ".pend_pd"}, pend_pd, (exp_out == OUT_ACK && !src) ? w : pd0);
    check({tag, ".pend_dbg"}, pend_dbg, (exp_out == OUT_ACK && src) ? w : dbg0);
    nwr = (trunc >= 0) ? 0 : ((n_pay > int'(MAXP)) ? int'(MAXP) : n_pay);
    check({tag, ".n_writes"}, wr_q.size(), nwr);
    for (int i = 0; i < wr_q.size() && i < nwr; i++)
      check($sformatf("%s.write%0d", tag, i), 32'(wr_q[i]), 32'({AW'(i), pay_q[i]}));
    if (trunc < 0) begin
      check({tag, ".header"}, header, hdr_w);
      if (framed) begin
        check({tag, ".wLength"}, wLength, {usb_w[7:0], usb_w[15:8]});
        check({tag, ".usb_req"}, {bmRequestType, bRequest}, usb_w[31:16]);
      end
    end
    idle_cycle();
    @(negedge clk);
    check({tag, ".quiet_after"}, {pulses, rx_ready}, 4'b0001);
    if (do_erase && exp_out == OUT_ACK) erase(src);
  endtask

  task automatic rand_msg(input int n);
    logic fr, sr;
    int np;
    logic [7:0] pv, mt;
    logic [15:0] wl;
    fr = 1'($urandom);
    sr = 1'($urandom);
    np = $urandom_range(0, 70);
    pv = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
    mt = ($urandom_range(0, 4) == 0) ? 8'($urandom) : mt_list[$urandom_range(0, 6)];
    wl = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 80)) : 16'(4 + np);
    run_msg($sformatf("rand%0d", n), sr, fr, {8'($urandom), 8'($urandom), wl[7:0], wl[15:8]},
            {pv, mt, 8'($urandom), 8'($urandom)}, np, -1, 1);
  endtask

  initial begin
    int got, k;
    logic rdy, seen;
    logic [7:0] pd0, wb;
    reset = 1'b0; rx_byte = '0; rx_valid = 1'b0; rx_last = 1'b0; rx_src = 1'b0;
    usb_framed = 1'b0; erase_pd = 1'b0; erase_dbg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", rx_ready, 1);
    check("reset.pending", {pend_pd, pend_dbg}, 0);
    check("reset.fields", {header, wLength, bmRequestType, bRequest} == 0, 1);
    check("reset.pulses_wr", {pulses, payload_wr_en}, 0);
    @(posedge clk); #1 reset = 1'b1;

    run_msg("pd_basic",   0, 0, 32'h0,        32'h01030200, 32, -1, 1);
    run_msg("dbg_framed", 1, 1, 32'hC1112400, 32'h01430100, 32, -1, 1);
    run_msg("bad_pv",     0, 0, 32'h0,        32'h02030200, 32, -1, 1);
    run_msg("bad_wlen",   1, 1, 32'hC1111000, 32'h01430100, 32, -1, 1);
    run_msg("over65",     0, 0, 32'h0,        32'h01420300, 65, -1, 1);
    run_msg("over70",     1, 1, 32'hC1114A00, 32'h01410200, 70, -1, 1);
    run_msg("max64",      0, 0, 32'h0,        32'h01410100, 64, -1, 1);
    run_msg("no_payload", 1, 0, 32'h0,        32'h017F0300, 0,  -1, 1);
    run_msg("framed_np",  0, 1, 32'h41120400, 32'h01020100, 0,  -1, 1);
    run_msg("hdr_last",   0, 0, 32'h0,        32'h01030200, 8,  2,  1);
    run_msg("pfx_last",   1, 1, 32'hC1112400, 32'h01030200, 8,  1,  1);
    run_msg("first_last", 0, 0, 32'h0,        32'h01030200, 8,  0,  1);
    run_msg("bad_type",   0, 0, 32'h0,        32'h01040000, 4,  -1, 1);
    for (int n = 0; n < 12; n++) rand_msg(n);

    // Payload stall: byte then TMO idle cycles expires the message
    build(0, 32'h0, 32'h01010100, 10);
    pd0 = pend_pd;
    drive_range(0, 9, -1, 0, 0);
    wait_outcome(TMO + 5, got, k, rdy);
    check("stall.outcome", got, OUT_TMO);
    check("stall.latency", k, TMO + 1);
    check("stall.ready_pend", {rx_ready, pend_pd}, {1'b1, pd0});

    // A gap one cycle short of the limit survives
    build(0, 32'h0, 32'h01020100, 6);
    wr_q = {};
    drive_range(0, 6, 9, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      idle_cycle();
      @(negedge clk);
      seen = seen | Error_timeout;
    end
    check("gap.no_timeout", seen, 0);
    drive_range(7, 9, 9, 0, 0);
    wait_outcome(8, got, k, rdy);
    check("gap.outcome", got, OUT_ACK);
    check("gap.latency", k, 3);
    check("gap.word", pend_pd, model_word(0, 32'h01020100));
    check("gap.n_writes", wr_q.size(), 6);
    erase(0);

    // Occupied target holds the message in POST until erased
    run_msg("occ_a", 0, 0, 32'h0, 32'h01010100, 2, -1, 0);
    build(0, 32'h0, 32'h01420200, 3);
    drive_range(0, 6, 6, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle_cycle();
      @(negedge clk);
      seen = seen | (pulses != 3'b000);
    end
    check("occ.held", {seen, rx_ready}, 2'b00);
    check("occ.kept", pend_pd, model_word(0, 32'h01010100));
    @(posedge clk); #1 erase_pd = 1'b1;
    @(posedge clk); #1 erase_pd = 1'b0;
    @(negedge clk);
    check("occ.ack_early", Ack_out, 0);
    @(posedge clk);
    @(negedge clk);
    check("occ.ack", Ack_out, 1);
    wb = model_word(0, 32'h01420200);
    check("occ.new_word", pend_pd, wb);

    // Never erased: POST expires
    build(0, 32'h0, 32'h01030000, 1);
    drive_range(0, 4, 4, 0, 0);
    wait_outcome(TMO + 10, got, k, rdy);
    check("post_tmo.outcome", got, OUT_TMO);
    check("post_tmo.latency", k, TMO + 2);
    check("post_tmo.kept", pend_pd, wb);
    erase(0);

    // Erase coinciding with the POST write loses to the write
    build(0, 32'h0, 32'h017F0100, 2);
    drive_range(0, 5, 5, 0, 0);
    idle_cycle();
    @(negedge clk);
    @(posedge clk); #1 erase_pd = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 erase_pd = 1'b0;
    @(negedge clk);
    check("tie.ack", Ack_out, 1);
    check("tie.word", pend_pd, model_word(0, 32'h017F0100));
    erase(0);

    // Reset mid-payload clears everything at once and leaves no status pulse
    run_msg("pre_rst", 1, 0, 32'h0, 32'h01020300, 3, -1, 0);
    build(1, 32'hC1110C00, 32'h01010000, 8);
    drive_range(0, 9, -1, 0, 1);
    #2 reset = 1'b0;
    #1;
    check("rst.wr_en", payload_wr_en, 0);
    check("rst.ready", rx_ready, 1);
    check("rst.pending", {pend_pd, pend_dbg}, 0);
    check("rst.fields", {header, wLength, bmRequestType, bRequest} == 0, 1);
    check("rst.pulses", pulses, 0);
    rx_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    seen = 1'b0;
    repeat (TMO + 5) begin
      @(negedge clk);
      seen = seen | (pulses != 3'b000);
    end
    check("rst.quiet", seen, 0);
    run_msg("post_rst", 0, 0, 32'h0, 32'h01430200, 5, -1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
